// File: rtl/btn_press_decoder_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button readers on the Nexys Video board.
//
// Contents:
//    ST_*            3-bit state encodings of the press-classifier FSM
//    btn_state_t     enum built on those encodings
//    DEF_*           default cycle constants for the 100 MHz system clock
//    cycles_fit()    elaboration helper: checks a counter width against a
//                    terminal count
// ---------------------------------------------------------------------------
package btn_pkg;

   // State encodings are fixed so they stay stable for debug probes and
   // for any future reader that reuses this package.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DB_PRESS = 3'd1;
   localparam logic [2:0] ST_PRESSED  = 3'd2;
   localparam logic [2:0] ST_LONG     = 3'd3;
   localparam logic [2:0] ST_DB_REL   = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      DB_PRESS = ST_DB_PRESS,
      PRESSED  = ST_PRESSED,
      LONG     = ST_LONG,
      DB_REL   = ST_DB_REL
   } btn_state_t;

   // 100 MHz defaults: 20 ms debounce, 1 s long press, 0.25 s repeat.
   localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
   localparam int DEF_LONG_CYCLES     = 100_000_000;
   localparam int DEF_REPEAT_CYCLES   = 25_000_000;
   localparam int DEF_CNT_W           = 28;

   // A counter that runs 0..cycles-1 needs cycles-1 to be representable;
   // requiring cycles itself to fit keeps a little headroom for saturation.
   function automatic bit cycles_fit(input int width, input int cycles);
      return (cycles >= 1) &&
             (longint'(cycles) <= ((longint'(1) << width) - 1));
   endfunction

endpackage

// File: rtl/btn_press_decoder_sync.sv
// ---------------------------------------------------------------------------
// btn_sync
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Kept as its own block so the switch readers can reuse it unchanged.
//
// Ports:
//    clk   in  1  destination clock
//    rst   in  1  synchronous reset, active-high; clears both flops
//    din   in  1  asynchronous input level
//    dout  out 1  synchronised level, two cycles behind din
// ---------------------------------------------------------------------------
module btn_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic meta;

   // The first flop may go metastable; the second gives it a full cycle
   // to resolve before anything downstream looks at the level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/btn_press_decoder.sv
// ---------------------------------------------------------------------------
// btn_press_decoder
// Reads one raw push-button, synchronises and debounces it, and classifies
// each press into one-cycle event pulses for the mode/LED control logic.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//    defined   -> repeat_pulse fires every REPEAT_CYCLES while long-held
//    undefined -> repeat logic is absent, repeat_pulse is tied to 0
//
// Parameters:
//    DEBOUNCE_CYCLES  stable cycles needed to accept an edge
//    LONG_CYCLES      cycles after the accepted press before a long press
//    REPEAT_CYCLES    auto-repeat period while long-held (macro only)
//    CNT_W            width of all internal counters
//
// Ports:
//    clk           in  1  100 MHz system clock
//    rst_n         in  1  synchronous reset, active-high despite the name
//    btn_in        in  1  raw asynchronous button, 1 = pressed
//    btn_level     out 1  debounced button state
//    press_pulse   out 1  one cycle on each accepted press
//    short_pulse   out 1  one cycle on release of a press that never went long
//    long_pulse    out 1  one cycle when the hold reaches LONG_CYCLES
//    repeat_pulse  out 1  one cycle per auto-repeat period
//    press_count   out 8  accepted presses, modulo 256
// ---------------------------------------------------------------------------
module btn_press_decoder
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic [7:0] press_count
);

   // Refuse to build with counters too narrow for the terminal counts.
   if (!(cycles_fit(CNT_W, DEBOUNCE_CYCLES) &&
         cycles_fit(CNT_W, LONG_CYCLES) &&
         cycles_fit(CNT_W, REPEAT_CYCLES))) begin : g_cnt_w_check
      $error("btn_press_decoder: CNT_W too narrow for the cycle parameters");
   end

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic btn_s;

   btn_state_t       state,       state_next;
   logic [CNT_W-1:0] db_cnt,      db_cnt_next;
   logic [CNT_W-1:0] hold_cnt,    hold_cnt_next;
   logic             long_flag,   long_flag_next;
   logic             level_next;
   logic             press_next;
   logic             short_next;
   logic             long_next;
   logic [7:0]       count_next;

   btn_sync u_sync (
      .clk  (clk),
      .rst  (rst_n),
      .din  (btn_in),
      .dout (btn_s)
   );

   // Next-state and next-output logic. Every output is computed here and
   // registered below, so pulses appear the cycle after the deciding edge.
   // Only one state can raise a pulse, which keeps the pulses exclusive.
   always_comb begin
      state_next     = state;
      db_cnt_next    = db_cnt;
      hold_cnt_next  = hold_cnt;
      long_flag_next = long_flag;
      level_next     = btn_level;
      press_next     = 1'b0;
      short_next     = 1'b0;
      long_next      = 1'b0;
      count_next     = press_count;

      case (state)
         IDLE: begin
            level_next = 1'b0;
            if (btn_s) begin
               state_next  = DB_PRESS;
               db_cnt_next = '0;
            end
         end

         DB_PRESS: begin
            if (!btn_s) begin
               state_next = IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_next     = PRESSED;
               level_next     = 1'b1;
               press_next     = 1'b1;
               count_next     = press_count + 8'd1;
               hold_cnt_next  = '0;
               long_flag_next = 1'b0;
            end else begin
               db_cnt_next = db_cnt + CNT_ONE;
            end
         end

         // Release is tested first so a release landing on the long
         // threshold cycle produces no long_pulse.
         PRESSED: begin
            hold_cnt_next = hold_cnt + CNT_ONE;
            if (!btn_s) begin
               state_next  = DB_REL;
               db_cnt_next = '0;
            end else if (hold_cnt == LONG_LAST) begin
               state_next     = LONG;
               long_next      = 1'b1;
               long_flag_next = 1'b1;
            end
         end

         LONG: begin
            if (hold_cnt != CNT_MAX) begin
               hold_cnt_next = hold_cnt + CNT_ONE;
            end
            if (!btn_s) begin
               state_next  = DB_REL;
               db_cnt_next = '0;
            end
         end

         // A glitch back to pressed resumes where the hold left off;
         // long_flag remembers whether that was PRESSED or LONG.
         DB_REL: begin
            if (btn_s) begin
               state_next = long_flag ? LONG : PRESSED;
            end else if (db_cnt == DB_LAST) begin
               state_next = IDLE;
               level_next = 1'b0;
               short_next = !long_flag;
            end else begin
               db_cnt_next = db_cnt + CNT_ONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= IDLE;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         long_flag   <= 1'b0;
         btn_level   <= 1'b0;
         press_pulse <= 1'b0;
         short_pulse <= 1'b0;
         long_pulse  <= 1'b0;
         press_count <= 8'd0;
      end else begin
         state       <= state_next;
         db_cnt      <= db_cnt_next;
         hold_cnt    <= hold_cnt_next;
         long_flag   <= long_flag_next;
         btn_level   <= level_next;
         press_pulse <= press_next;
         short_pulse <= short_next;
         long_pulse  <= long_next;
         press_count <= count_next;
      end
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] rep_cnt, rep_cnt_next;
   logic             repeat_next;

   // The repeat counter starts at 0 on the long_pulse cycle, so the first
   // repeat lands REPEAT_CYCLES after long_pulse. On the release cycle the
   // release wins and the counter simply freezes through DB_REL; it is
   // cleared in every other state.
   always_comb begin
      rep_cnt_next = rep_cnt;
      repeat_next  = 1'b0;
      case (state)
         LONG: begin
            if (btn_s) begin
               if (rep_cnt == REP_LAST) begin
                  repeat_next  = 1'b1;
                  rep_cnt_next = '0;
               end else begin
                  rep_cnt_next = rep_cnt + CNT_ONE;
               end
            end
         end
         DB_REL: begin
            if (state_next == IDLE) begin
               rep_cnt_next = '0;
            end
         end
         default: begin
            rep_cnt_next = '0;
         end
      endcase
   end

   // Repeat counter and its registered pulse.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         rep_cnt      <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         rep_cnt      <= rep_cnt_next;
         repeat_pulse <= repeat_next;
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_decoder.sv
// ---------------------------------------------------------------------------
// tb_btn_press_decoder
// Directed bench for btn_press_decoder with small cycle counts
// (DEBOUNCE 4, LONG 20, REPEAT 8). Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, so each tick() observes
// what the preceding edge registered. A raw edge on btn_in shows up as a
// pulse on the 7th tick after it is applied (2 sync + 1 detect + 4 debounce).
// ---------------------------------------------------------------------------
module tb_btn_press_decoder;

   logic       clk;
   logic       rst_n;
   logic       btn_in;
   logic       btn_level;
   logic       press_pulse;
   logic       short_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic [7:0] press_count;

   int n_checks;
   int n_fail;
   int cyc;
   int press_seen, short_seen, long_seen, repeat_seen;
   int press_cyc, long_cyc, first_rep_cyc, last_rep_cyc;

   btn_press_decoder #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .REPEAT_CYCLES   (8),
      .CNT_W           (28)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_in       (btn_in),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .press_count  (press_count)
   );

   // 100 MHz-style clock; the absolute period does not matter here.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock, then log every pulse and confirm that at most one
   // event pulse is high in the cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (press_pulse) begin
         press_seen++;
         press_cyc = cyc;
      end
      if (short_pulse) short_seen++;
      if (long_pulse) begin
         long_seen++;
         long_cyc = cyc;
      end
      if (repeat_pulse) begin
         repeat_seen++;
         if (repeat_seen == 1) first_rep_cyc = cyc;
         last_rep_cyc = cyc;
      end
      check_output("pulses_exclusive",
                   32'($onehot0({press_pulse, short_pulse, long_pulse, repeat_pulse})),
                   32'd1);
   endtask

   task automatic apply_stimulus(input logic value, input int cycles);
      btn_in = value;
      for (int k = 0; k < cycles; k++) tick();
   endtask

   task automatic clear_seen();
      press_seen    = 0;
      short_seen    = 0;
      long_seen     = 0;
      repeat_seen   = 0;
      press_cyc     = -1;
      long_cyc      = -1;
      first_rep_cyc = -1;
      last_rep_cyc  = -1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      clear_seen();
      rst_n  = 1'b0;
      btn_in = 1'b0;
      tick();

      // Reset held with the button pressed: everything must stay cleared.
      rst_n = 1'b1;
      apply_stimulus(1'b1, 3);
      check_output("reset_level", 32'(btn_level), 32'd0);
      check_output("reset_count", 32'(press_count), 32'd0);
      check_output("reset_pulses",
                   32'({press_pulse, short_pulse, long_pulse, repeat_pulse}), 32'd0);
      btn_in = 1'b0;
      rst_n  = 1'b0;
      apply_stimulus(1'b0, 4);
      clear_seen();

      // Bounces of 3 and 4 raw cycles are both shorter than the debounce.
      $display("[TB] bounce rejection");
      apply_stimulus(1'b1, 3);
      apply_stimulus(1'b0, 12);
      apply_stimulus(1'b1, 4);
      apply_stimulus(1'b0, 12);
      check_output("bounce_level", 32'(btn_level), 32'd0);
      check_output("bounce_press_seen", 32'(press_seen), 32'd0);
      check_output("bounce_other_pulses", 32'(short_seen + long_seen + repeat_seen), 32'd0);
      check_output("bounce_count", 32'(press_count), 32'd0);

      // Short press of 10 raw cycles.
      $display("[TB] short press");
      clear_seen();
      apply_stimulus(1'b1, 6);
      check_output("short_press_early", 32'({btn_level, press_pulse}), 32'd0);
      apply_stimulus(1'b1, 1);
      check_output("short_press_pulse", 32'(press_pulse), 32'd1);
      check_output("short_press_level", 32'(btn_level), 32'd1);
      check_output("short_press_count", 32'(press_count), 32'd1);
      apply_stimulus(1'b1, 3);
      apply_stimulus(1'b0, 6);
      check_output("short_rel_early", 32'({btn_level, short_pulse}), 32'd2);
      apply_stimulus(1'b0, 1);
      check_output("short_rel_pulse", 32'(short_pulse), 32'd1);
      check_output("short_rel_level", 32'(btn_level), 32'd0);
      apply_stimulus(1'b0, 5);
      check_output("short_counts", 32'({press_seen[3:0], short_seen[3:0], long_seen[3:0]}),
                   32'h110);

      // Long press of 46 raw cycles.
      $display("[TB] long press");
      clear_seen();
      apply_stimulus(1'b1, 46);
      check_output("long_press_seen", 32'(press_seen), 32'd1);
      check_output("long_seen", 32'(long_seen), 32'd1);
      check_output("long_delay", 32'(long_cyc - press_cyc), 32'd20);
      check_output("long_level", 32'(btn_level), 32'd1);
      check_output("long_count", 32'(press_count), 32'd2);
`ifdef BTN_AUTO_REPEAT_EN
      check_output("repeat_seen", 32'(repeat_seen), 32'd2);
      check_output("repeat_first", 32'(first_rep_cyc - long_cyc), 32'd8);
      check_output("repeat_second", 32'(last_rep_cyc - long_cyc), 32'd16);
`else
      check_output("repeat_seen", 32'(repeat_seen), 32'd0);
`endif
      apply_stimulus(1'b0, 6);
      check_output("long_rel_early", 32'(btn_level), 32'd1);
      apply_stimulus(1'b0, 1);
      check_output("long_rel_level", 32'(btn_level), 32'd0);
      apply_stimulus(1'b0, 5);
      check_output("long_no_short", 32'(short_seen), 32'd0);
      check_output("long_once", 32'(long_seen), 32'd1);
`ifdef BTN_AUTO_REPEAT_EN
      check_output("repeat_after_rel", 32'(repeat_seen), 32'd2);
`else
      check_output("repeat_after_rel", 32'(repeat_seen), 32'd0);
`endif

      // Two-cycle low glitch while pressed, then a real release.
      $display("[TB] release bounce");
      clear_seen();
      apply_stimulus(1'b1, 7);
      check_output("glitch_press_pulse", 32'(press_pulse), 32'd1);
      apply_stimulus(1'b1, 2);
      apply_stimulus(1'b0, 2);
      apply_stimulus(1'b1, 8);
      check_output("glitch_level", 32'(btn_level), 32'd1);
      check_output("glitch_no_short", 32'(short_seen), 32'd0);
      check_output("glitch_press_once", 32'(press_seen), 32'd1);
      apply_stimulus(1'b0, 7);
      check_output("glitch_rel_short", 32'(short_pulse), 32'd1);
      apply_stimulus(1'b0, 5);
      check_output("glitch_short_once", 32'(short_seen), 32'd1);
      check_output("glitch_no_long", 32'(long_seen), 32'd0);
      check_output("glitch_count", 32'(press_count), 32'd3);

      // Shortest accepted press: 5 raw cycles high.
      $display("[TB] minimum press");
      clear_seen();
      apply_stimulus(1'b1, 5);
      apply_stimulus(1'b0, 1);
      check_output("min_press_early", 32'(press_pulse), 32'd0);
      apply_stimulus(1'b0, 1);
      check_output("min_press_pulse", 32'(press_pulse), 32'd1);
      check_output("min_press_count", 32'(press_count), 32'd4);
      apply_stimulus(1'b0, 4);
      check_output("min_short_early", 32'(short_pulse), 32'd0);
      apply_stimulus(1'b0, 1);
      check_output("min_short_pulse", 32'(short_pulse), 32'd1);
      apply_stimulus(1'b0, 3);

      // Fill the counter up to 256 accepted presses in total.
      $display("[TB] counter wrap");
      clear_seen();
      for (int i = 0; i < 252; i++) begin
         if (i == 251) check_output("wrap_count_255", 32'(press_count), 32'd255);
         apply_stimulus(1'b1, 5);
         apply_stimulus(1'b0, 10);
      end
      check_output("wrap_count_0", 32'(press_count), 32'd0);
      check_output("wrap_press_seen", 32'(press_seen), 32'd252);
      check_output("wrap_short_seen", 32'(short_seen), 32'd252);
      check_output("wrap_long_seen", 32'(long_seen), 32'd0);

      // Reset arriving while a press is being debounced.
      $display("[TB] reset during debounce");
      apply_stimulus(1'b1, 5);
      apply_stimulus(1'b0, 10);
      check_output("pre_reset_count", 32'(press_count), 32'd1);
      clear_seen();
      apply_stimulus(1'b1, 4);
      rst_n = 1'b1;
      apply_stimulus(1'b1, 1);
      check_output("mid_reset_outputs",
                   32'({btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse}),
                   32'd0);
      check_output("mid_reset_count", 32'(press_count), 32'd0);
      rst_n = 1'b0;
      apply_stimulus(1'b0, 12);
      check_output("post_reset_pulses",
                   32'(press_seen + short_seen + long_seen + repeat_seen), 32'd0);
      check_output("post_reset_level", 32'(btn_level), 32'd0);
      check_output("post_reset_count", 32'(press_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
